// File: rtl/mlp_p_neuron.sv
// Fully-connected MLP evaluator: M-1 layers of N neurons, P MAC lanes, one input term per cycle.
// Layer activations ping-pong between two buffer banks; each neuron is rounded, saturated, then activated.
module mlp_p_neuron #(
    parameter int M   = 3,
    parameter int N   = 3,
    parameter int P   = 1,
    parameter int QM  = 3,
    parameter int QN  = 5,
    parameter int WM  = 3,
    parameter int WN  = 5,
    parameter int ACT = 1
) (
    input  logic                                  clk,
    input  logic                                  nrst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [N-1:0][QM+QN-1:0]               x,
    input  logic [M-2:0][N-1:0][N-1:0][WM+WN-1:0] w,
    input  logic [M-2:0][N-1:0][QM+QN-1:0]        b,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [N-1:0][QM+QN-1:0]               outputs,
    output logic                                  busy,
    output logic                                  sat
);
    localparam int D  = QM + QN;
    localparam int W  = WM + WN;
    localparam int AW = D + W + $clog2(N + 1);
    localparam int NG = N / P;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int GW = (NG > 1) ? $clog2(NG) : 1;
    localparam int LW = (M > 2) ? $clog2(M - 1) : 1;

    localparam logic signed [AW-1:0] HALF = AW'(1) <<< (WN - 1);
    localparam logic signed [AW-1:0] MAXV = AW'((1 <<< (D - 1)) - 1);
    localparam logic signed [AW-1:0] MINV = -(AW'(1) <<< (D - 1));

    typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

    function automatic logic signed [AW-1:0] round_shift(input logic signed [AW-1:0] a);
        return (a + HALF) >>> WN;
    endfunction

    function automatic logic overflows(input logic signed [AW-1:0] v);
        return (v > MAXV) || (v < MINV);
    endfunction

    function automatic logic signed [D-1:0] saturate(input logic signed [AW-1:0] v);
        if (v > MAXV) return {1'b0, {(D-1){1'b1}}};
        if (v < MINV) return {1'b1, {(D-1){1'b0}}};
        return v[D-1:0];
    endfunction

    function automatic logic signed [D-1:0] activate(input logic signed [D-1:0] v);
        if (ACT == 1 && v[D-1]) return '0;
        return v;
    endfunction

    state_t                               state_q;
    logic [KW-1:0]                        k_q;
    logic [GW-1:0]                        g_q;
    logic [LW-1:0]                        l_q;
    logic                                 rd_q;
    logic                                 fin_q;
    logic                                 in_ready_q;
    logic                                 out_valid_q;
    logic                                 busy_q;
    logic                                 sat_q;
    logic [N-1:0][D-1:0]                  outputs_q;
    logic signed [AW-1:0]                 acc_q [P];
    logic signed [D-1:0]                  buf_q [2][N];
    logic [M-2:0][N-1:0][N-1:0][W-1:0]    w_q;
    logic [M-2:0][N-1:0][D-1:0]           b_q;

    logic                                 accept;
    logic signed [D-1:0]                  xk;
    logic [KW-1:0]                        jidx [P];
    logic signed [D+W-1:0]                prod [P];
    logic signed [AW-1:0]                 bias [P];
    logic signed [AW-1:0]                 rnd  [P];
    logic signed [D-1:0]                  res  [P];
    logic [P-1:0]                         ovf;

    assign accept    = (state_q == IDLE) && in_ready_q && in_valid;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sat       = sat_q;
    assign outputs   = outputs_q;

    // Lane p of group g owns neuron g*P+p; all lanes share the current input term k.
    always_comb begin
        xk  = buf_q[rd_q][k_q];
        ovf = '0;
        for (int p = 0; p < P; p++) begin
            jidx[p] = KW'(int'(g_q) * P + p);
            prod[p] = (D+W)'(xk) * (D+W)'($signed(w_q[l_q][jidx[p]][k_q]));
            bias[p] = AW'($signed(b_q[l_q][jidx[p]])) <<< WN;
            rnd[p]  = round_shift(acc_q[p]);
            res[p]  = activate(saturate(rnd[p]));
            ovf[p]  = overflows(rnd[p]);
        end
    end

    // Weights and biases are only sampled on accept, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            w_q <= w;
            b_q <= b;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            g_q         <= '0;
            l_q         <= '0;
            rd_q        <= 1'b0;
            fin_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            sat_q       <= 1'b0;
            outputs_q   <= '0;
            acc_q       <= '{default: '0};
            buf_q       <= '{default: '0};
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        state_q    <= MAC;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        sat_q      <= 1'b0;
                        k_q        <= '0;
                        g_q        <= '0;
                        l_q        <= '0;
                        rd_q       <= 1'b0;
                        fin_q      <= 1'b0;
                        for (int n = 0; n < N; n++) buf_q[0][n] <= x[n];
                    end
                end
                MAC: begin
                    // The bias is folded in on the first term instead of a separate preload cycle.
                    for (int p = 0; p < P; p++)
                        acc_q[p] <= ((k_q == '0) ? bias[p] : acc_q[p]) + AW'(prod[p]);
                    if (k_q == KW'(N - 1)) begin
                        k_q     <= '0;
                        state_q <= WRITE;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                WRITE: begin
                    if (fin_q) begin
                        // Extra commit cycle: the final bank is copied to the held output register.
                        for (int n = 0; n < N; n++) outputs_q[n] <= buf_q[~rd_q][n];
                        out_valid_q <= 1'b1;
                        fin_q       <= 1'b0;
                        state_q     <= DONE;
                    end else begin
                        for (int p = 0; p < P; p++) buf_q[~rd_q][jidx[p]] <= res[p];
                        if (|ovf) sat_q <= 1'b1;
                        if (g_q == GW'(NG - 1)) begin
                            g_q <= '0;
                            if (l_q == LW'(M - 2)) begin
                                fin_q <= 1'b1;
                            end else begin
                                l_q     <= l_q + 1'b1;
                                rd_q    <= ~rd_q;
                                state_q <= MAC;
                            end
                        end else begin
                            g_q     <= g_q + 1'b1;
                            state_q <= MAC;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mlp_p_neuron.sv
// Bench for mlp_p_neuron: three instances (P=1 ReLU, P=3 ReLU, P=1 identity) sharing x/w/b and reset.
module tb_mlp_p_neuron;
    localparam int M  = 3;
    localparam int N  = 3;
    localparam int D  = 8;
    localparam int W  = 8;
    localparam int NU = 3;
    localparam int NT = 11;

    typedef logic [N-1:0][D-1:0] vec_t;
    typedef struct { vec_t o; logic s; int lat; } exp_t;
    typedef struct { logic [1:0] unit; logic [7:0] xv, wv, bv, eo; logic es; } rec_t;

    logic                              clk = 1'b0;
    logic                              nrst;
    logic [N-1:0][D-1:0]               x;
    logic [M-2:0][N-1:0][N-1:0][W-1:0] w;
    logic [M-2:0][N-1:0][D-1:0]        b;
    logic [NU-1:0]                     in_valid, in_ready, out_valid, out_ready, busy, sat;
    logic [NU-1:0][N-1:0][D-1:0]       outs;

    exp_t sbq[$];
    rec_t tbl [NT];
    int   total = 0;
    int   bad   = 0;
    logic last_sat = 1'b0;

    always #5 clk = ~clk;

    mlp_p_neuron #(.M(M), .N(N), .P(1), .ACT(1)) u0 (
        .clk(clk), .nrst(nrst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .x(x), .w(w), .b(b), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .outputs(outs[0]), .busy(busy[0]), .sat(sat[0]));

    mlp_p_neuron #(.M(M), .N(N), .P(3), .ACT(1)) u1 (
        .clk(clk), .nrst(nrst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .x(x), .w(w), .b(b), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .outputs(outs[1]), .busy(busy[1]), .sat(sat[1]));

    mlp_p_neuron #(.M(M), .N(N), .P(1), .ACT(0)) u2 (
        .clk(clk), .nrst(nrst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .x(x), .w(w), .b(b), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .outputs(outs[2]), .busy(busy[2]), .sat(sat[2]));

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic set_uniform(input logic [7:0] xv, input logic [7:0] wv, input logic [7:0] bv);
        for (int n = 0; n < N; n++) x[n] = xv;
        for (int l = 0; l < M-1; l++)
            for (int j = 0; j < N; j++) begin
                b[l][j] = bv;
                for (int k = 0; k < N; k++) w[l][j][k] = wv;
            end
    endtask

    function automatic logic [7:0] rsmall();
        logic signed [5:0] r;
        r = 6'($urandom);
        return 8'(r);
    endfunction

    // Reference: integer evaluation of round-half-up, shift, clamp and activation per neuron.
    function automatic void model(input int act, output vec_t o, output logic s);
        int cur [N];
        int nxt [N];
        int acc;
        s = 1'b0;
        for (int n = 0; n < N; n++) cur[n] = int'($signed(x[n]));
        for (int l = 0; l < M-1; l++) begin
            for (int j = 0; j < N; j++) begin
                acc = int'($signed(b[l][j])) * 32;
                for (int k = 0; k < N; k++) acc += cur[k] * int'($signed(w[l][j][k]));
                acc = (acc + 16) >>> 5;
                if (acc > 127) begin
                    acc = 127;
                    s = 1'b1;
                end else if (acc < -128) begin
                    acc = -128;
                    s = 1'b1;
                end
                if (act != 0 && acc < 0) acc = 0;
                nxt[j] = acc;
            end
            cur = nxt;
        end
        for (int n = 0; n < N; n++) o[n] = 8'(cur[n]);
    endfunction

    task automatic accept(input logic [1:0] u);
        int cyc;
        cyc = 0;
        @(negedge clk);
        while (!in_ready[u] && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("in_ready_idle", 32'(in_ready[u]), 32'd1);
        in_valid[u] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[u] = 1'b0;
        chk("busy_after_accept", 32'(busy[u]), 32'd1);
        chk("in_ready_after_accept", 32'(in_ready[u]), 32'd0);
        chk("sat_cleared_on_accept", 32'(sat[u]), 32'd0);
    endtask

    task automatic wait_out(input logic [1:0] u);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (!out_valid[u] && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("out_valid_rise", 32'(out_valid[u]), 32'd1);
        chk("busy_in_done", 32'(busy[u]), 32'd1);
        chk("in_ready_in_done", 32'(in_ready[u]), 32'd0);
        if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: output with no expected entry");
        end else begin
            e = sbq.pop_front();
            chk("outputs", 32'(outs[u]), 32'(e.o));
            chk("sat", 32'(sat[u]), 32'(e.s));
            chk("latency", 32'(cyc), 32'(e.lat));
            last_sat = e.s;
        end
    endtask

    task automatic release_out(input logic [1:0] u);
        @(negedge clk);
        out_ready[u] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[u] = 1'b0;
        chk("out_valid_fall", 32'(out_valid[u]), 32'd0);
        chk("busy_idle", 32'(busy[u]), 32'd0);
        chk("in_ready_back", 32'(in_ready[u]), 32'd1);
        chk("sat_held", 32'(sat[u]), 32'(last_sat));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        nrst      = 1'b0;
        in_valid  = '0;
        out_ready = '0;
        set_uniform(8'h00, 8'h00, 8'h00);

        tbl[0]  = '{2'd0, 8'h10, 8'h10, 8'h10, 8'h4C, 1'b0};
        tbl[1]  = '{2'd1, 8'h10, 8'h10, 8'h10, 8'h4C, 1'b0};
        tbl[2]  = '{2'd2, 8'h10, 8'hF0, 8'h00, 8'h24, 1'b0};
        tbl[3]  = '{2'd0, 8'h10, 8'hF0, 8'h00, 8'h00, 1'b0};
        tbl[4]  = '{2'd0, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 1'b1};
        tbl[5]  = '{2'd0, 8'h10, 8'h10, 8'h10, 8'h4C, 1'b0};
        tbl[6]  = '{2'd2, 8'h80, 8'h80, 8'h00, 8'h80, 1'b1};
        tbl[7]  = '{2'd2, 8'hF8, 8'h20, 8'h08, 8'hD8, 1'b0};
        tbl[8]  = '{2'd2, 8'h01, 8'h10, 8'h00, 8'h03, 1'b0};
        tbl[9]  = '{2'd2, 8'hFF, 8'h10, 8'h00, 8'hFF, 1'b0};
        tbl[10] = '{2'd1, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 1'b1};

        #2;
        chk("rst_outputs", 32'(outs[0]), 32'd0);
        chk("rst_out_valid", 32'(out_valid[0]), 32'd0);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_sat", 32'(sat[0]), 32'd0);
        chk("rst_in_ready", 32'(in_ready[0]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready_held", 32'(in_ready[1]), 32'd0);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_first_edge", 32'(in_ready[0]), 32'd1);

        for (int i = 0; i < NT; i++) begin
            set_uniform(tbl[i].xv, tbl[i].wv, tbl[i].bv);
            e.o   = {N{tbl[i].eo}};
            e.s   = tbl[i].es;
            e.lat = (tbl[i].unit == 2'd1) ? 9 : 25;
            sbq.push_back(e);
            accept(tbl[i].unit);
            wait_out(tbl[i].unit);
            release_out(tbl[i].unit);
        end

        for (int i = 0; i < 6; i++) begin
            logic [1:0] u;
            u = 2'(i % 3);
            for (int n = 0; n < N; n++) x[n] = rsmall();
            for (int l = 0; l < M-1; l++)
                for (int j = 0; j < N; j++) begin
                    b[l][j] = rsmall();
                    for (int k = 0; k < N; k++) w[l][j][k] = rsmall();
                end
            model((u == 2'd2) ? 0 : 1, e.o, e.s);
            e.lat = (u == 2'd1) ? 9 : 25;
            sbq.push_back(e);
            accept(u);
            wait_out(u);
            release_out(u);
        end

        // Consumer stalls for 10 cycles while a stray in_valid toggles.
        set_uniform(8'h10, 8'h10, 8'h10);
        e.o = {N{8'h4C}};
        e.s = 1'b0;
        e.lat = 25;
        sbq.push_back(e);
        accept(2'd0);
        wait_out(2'd0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid[0] = (c % 2 == 0);
            x[0] = 8'h7F;
            @(posedge clk);
            #1;
            chk("hold_out_valid", 32'(out_valid[0]), 32'd1);
            chk("hold_outputs", 32'(outs[0]), 32'h004C4C4C);
            chk("hold_in_ready", 32'(in_ready[0]), 32'd0);
        end
        @(negedge clk);
        in_valid[0] = 1'b0;
        release_out(2'd0);
        @(posedge clk);
        #1;
        chk("stray_valid_no_accept", 32'(busy[0]), 32'd0);

        // Reset partway through a transaction.
        set_uniform(8'h10, 8'h10, 8'h10);
        accept(2'd0);
        repeat (11) @(posedge clk);
        #2;
        nrst = 1'b0;
        #1;
        chk("midrst_outputs", 32'(outs[0]), 32'd0);
        chk("midrst_busy", 32'(busy[0]), 32'd0);
        chk("midrst_out_valid", 32'(out_valid[0]), 32'd0);
        chk("midrst_in_ready", 32'(in_ready[0]), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        e.o = {N{8'h4C}};
        e.s = 1'b0;
        e.lat = 25;
        sbq.push_back(e);
        accept(2'd0);
        wait_out(2'd0);
        release_out(2'd0);

        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mlp_p_neuron.md
MLP_P_NEURON -- requirements
Module: mlp_p_neuron

Interface
REQ-001 SHALL have parameter M, default 3: layer count including input; M-1 weight layers; M>=2.
REQ-002 SHALL have parameter N, default 3: neurons per layer, equal to input count.
REQ-003 SHALL have parameter P, default 1: parallel MAC units; N mod P = 0.
REQ-004 SHALL have parameters QM=3, QN=5: signed data format, integer bits QM and fraction bits QN, width D=QM+QN.
REQ-005 SHALL have parameters WM=3, WN=5: signed weight format, width W=WM+WN.
REQ-006 SHALL have parameter ACT, default 1: 0 = identity, 1 = ReLU.
REQ-007 Ports SHALL be:
- clk  in  1  single clock, rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  x/w/b presented.
- in_ready  out  1  block can accept.
- x  in  D x N  input vector.
- w  in  W x [M-1][N][N]  w[l][j][k] = weight from input k to neuron j, layer l.
- b  in  D x [M-1][N]  bias, data format.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts.
- outputs  out  D x N  final-layer activations.
- busy  out  1  transaction in progress.
- sat  out  1  saturation occurred in the current or last transaction.

Function
REQ-008 SHALL accept a transaction when in_valid & in_ready on a rising edge, registering x, w and b internally; inputs are don't-care afterwards.
REQ-009 in_ready SHALL be 1 only in IDLE.
REQ-010 FSM states SHALL be IDLE, MAC, WRITE and DONE, with these transitions:
- IDLE->MAC on accept.
- MAC->WRITE after N MAC cycles per group.
- WRITE->MAC for the next group or layer.
- WRITE->DONE after the last group of layer M-2.
- DONE->IDLE on out_ready.
REQ-011 Each group SHALL process P consecutive neurons j=g*P..g*P+P-1 in parallel; one input k per cycle, k=0..N-1.
REQ-012 Product SHALL be full-precision D x W signed, with QN+WN fraction bits.
REQ-013 Accumulator width SHALL be D+W+ceil(log2(N+1)), so no internal overflow.
REQ-014 Bias SHALL be sign-extended and shifted left WN before being added.
REQ-015 Neuron result SHALL be:
- add 2^(WN-1) to the sum;
- arithmetic shift right by WN;
- saturate to [-2^(D-1), 2^(D-1)-1];
- apply ACT.
REQ-016 ACT SHALL apply to every layer, including the last.
REQ-017 Layer l results SHALL feed layer l+1; the layer buffer SHALL be double-banked so later neurons still read unmodified layer l values.
REQ-018 Latency from accept edge to out_valid=1 SHALL be exactly (M-1)*(N/P)*(N+1)+1 cycles.
REQ-019 In DONE, out_valid SHALL be 1 and outputs SHALL be stable until out_ready=1; out_valid SHALL fall on the following edge.
REQ-020 busy SHALL be 1 in MAC, WRITE and DONE.
REQ-021 sat SHALL be cleared on accept and set sticky when any neuron of any layer saturates; it SHALL hold after DONE until the next accept.
REQ-022 in_valid while not in IDLE SHALL be ignored with no effect.

Reset
REQ-023 nrst=0 SHALL asynchronously force IDLE and clear all accumulators and layer buffers.
REQ-024 During reset, outputs SHALL be 0, out_valid=0, busy=0, sat=0 and in_ready=0.
REQ-025 in_ready SHALL become 1 on the first rising edge with nrst=1.
REQ-026 Reset mid-transaction SHALL abandon it completely; the next accept SHALL behave as from power-up.

Verification
(Defaults unless stated: M=3, N=3, QM=QN... i.e. QM=3, QN=5, WM=3, WN=5.)
REQ-027 P=1, ACT=1, all x/w/b=0x10 (0.5) -> after 25 cycles out_valid=1 and outputs all 0x4C (2.375), sat=0; layer-1 internal value 0x28.
REQ-028 Same stimulus with P=3 -> identical outputs 0x4C, latency 9 cycles.
REQ-029 x=0x10, w=0xF0 (-0.5), b=0:
- ACT=0 -> outputs 0x24, layer-1 internal value 0xE8;
- ACT=1 -> outputs 0x00.
REQ-030 x=w=0x7F, b=0x7F -> outputs all 0x7F, sat=1; a following 0x10 transaction -> sat=0.
REQ-031 Hold out_ready=0 for 10 cycles after out_valid -> out_valid and outputs unchanged, in_ready=0, extra in_valid ignored; out_ready=1 -> IDLE next edge.
REQ-032 nrst pulse low at cycle 12 of a transaction -> outputs=0, busy=0 immediately; a new 0x10 transaction -> 0x4C after 25 cycles.
